sr_request_conditioner: RTL and testbench

Upstream conditioning stage for the SR flip-flop. It takes two raw, asynchronous, possibly bouncing request lines (set and clear) and turns them into clean, synchronous, one-cycle `s`/`r` pulses. It guarantees the flip-flop never sees S=R=1, and it tracks the state the flip-flop is expected to hold. Its `s_out`/`r_out` drive the flip-flop's `s`/`r` inputs directly, on the same `clk`.

---
 rtl/sr_cond_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/sr_request_conditioner.sv | 66 ++++++
 tb/tb_sr_request_conditioner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cond_pkg.sv
// Shared definitions for the SR request conditioner: debounce state encoding,
// the default debounce length and the counter width it needs.
package sr_cond_pkg;

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } deb_state_e;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   // Smallest counter width that can hold a count of n.
   function automatic int min_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DEFAULT_MIN_CNT_W = min_cnt_w(DEFAULT_DEBOUNCE_CYCLES);

endpackage

// File: rtl/debounce_channel.sv
// One request channel: 2-flop synchronizer, debounce FSM with counter, and a
// one-cycle event flagging acceptance of a rising level.
module debounce_channel
   import sr_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise_evt
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1;
   logic             sync2;
   deb_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             done;

   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   // The count includes the current synchronized cycle, so a change seen in
   // LOW/HIGH with DEBOUNCE_CYCLES=1 is accepted immediately.
   assign done    = (cnt_inc >= LIMIT);

   assign rise_evt = ((state == LOW) || (state == RISE_CHK)) && sync2 && done;

   // NOTE: every register here uses non-blocking assignments so all flops
   // update from the same pre-edge values, as real hardware does.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= LOW;
         cnt   <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         unique case (state)
            LOW: begin
               if (sync2) begin
                  if (done) begin
                     state <= HIGH;
                     cnt   <= '0;
                  end else begin
                     state <= RISE_CHK;
                     cnt   <= cnt_inc;
                  end
               end
            end
            RISE_CHK: begin
               if (!sync2) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (done) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            HIGH: begin
               if (!sync2) begin
                  if (done) begin
                     state <= LOW;
                     cnt   <= '0;
                  end else begin
                     state <= FALL_CHK;
                     cnt   <= cnt_inc;
                  end
               end
            end
            FALL_CHK: begin
               if (sync2) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (done) begin
                  state <= LOW;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sr_request_conditioner.sv
// Turns raw set/clear requests into clean one-cycle s/r pulses for an SR
// flip-flop, never both at once, and tracks the flip-flop's expected state.
module sr_request_conditioner
   import sr_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic s_out,
   output logic r_out,
   output logic q_track,
   output logic conflict,
   output logic conflict_seen
);

   logic set_evt;
   logic clr_evt;

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_set_ch (
      .clk     (clk),
      .rst     (rst),
      .din     (set_req),
      .rise_evt(set_evt)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_clr_ch (
      .clk     (clk),
      .rst     (rst),
      .din     (clr_req),
      .rise_evt(clr_evt)
   );

   // Simultaneous acceptance suppresses both pulses so the flip-flop never
   // sees S=R=1; the tracked state is left alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_out         <= 1'b0;
         r_out         <= 1'b0;
         q_track       <= 1'b0;
         conflict      <= 1'b0;
         conflict_seen <= 1'b0;
      end else begin
         s_out    <= set_evt & ~clr_evt;
         r_out    <= clr_evt & ~set_evt;
         conflict <= set_evt & clr_evt;
         if (set_evt && clr_evt) begin
            conflict_seen <= 1'b1;
         end else if (set_evt) begin
            q_track <= 1'b1;
         end else if (clr_evt) begin
            q_track <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sr_request_conditioner.sv
// Directed bench for sr_request_conditioner: default N=4 instance plus an
// N=1 instance, with expected pulse timing worked out per edge.
module tb_sr_request_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_req = 1'b0, clr_req = 1'b0;
   logic s_out, r_out, q_track, conflict, conflict_seen;
   logic set1 = 1'b0, clr1 = 1'b0;
   logic s_out1, r_out1, q_track1, conflict1, conflict_seen1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sr_request_conditioner dut (
      .clk          (clk),
      .rst          (rst),
      .set_req      (set_req),
      .clr_req      (clr_req),
      .s_out        (s_out),
      .r_out        (r_out),
      .q_track      (q_track),
      .conflict     (conflict),
      .conflict_seen(conflict_seen)
   );

   sr_request_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .set_req      (set1),
      .clr_req      (clr1),
      .s_out        (s_out1),
      .r_out        (r_out1),
      .q_track      (q_track1),
      .conflict     (conflict1),
      .conflict_seen(conflict_seen1)
   );

   // s_out and r_out must never be high together on either instance.
   always @(negedge clk) begin
      total++;
      if ((s_out & r_out) !== 1'b0 || (s_out1 & r_out1) !== 1'b0) begin
         bad++;
         $display("FAIL exclusive: s&r=%b s1&r1=%b required 0", s_out & r_out, s_out1 & r_out1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({s_out, r_out, q_track, conflict, conflict_seen} !== 5'b0) begin
         bad++;
         $display("FAIL reset: outputs=%b required 00000",
                  {s_out, r_out, q_track, conflict, conflict_seen});
      end
      total++;
      if ({s_out1, r_out1, q_track1, conflict1, conflict_seen1} !== 5'b0) begin
         bad++;
         $display("FAIL reset_n1: outputs=%b required 00000",
                  {s_out1, r_out1, q_track1, conflict1, conflict_seen1});
      end
   endtask

   task automatic test_set_hold();
      set_req = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         step();
         total++;
         if ({s_out, r_out, q_track} !== {e == 6, 1'b0, e >= 6}) begin
            bad++;
            $display("FAIL set_hold edge %0d: s,r,q=%b required %b", e,
                     {s_out, r_out, q_track}, {e == 6, 1'b0, e >= 6});
         end
      end
      set_req = 1'b0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_bounce();
      logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_req = pat[i];
         step();
         total++;
         if (s_out !== 1'b0) begin
            bad++;
            $display("FAIL bounce cycle %0d: s_out=%b required 0", i, s_out);
         end
      end
      set_req = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         total++;
         if ({s_out, q_track} !== {e == 6, e >= 6}) begin
            bad++;
            $display("FAIL bounce_hold edge %0d: s,q=%b required %b", e,
                     {s_out, q_track}, {e == 6, e >= 6});
         end
      end
   endtask

   task automatic test_sequence();
      set_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if ({s_out, r_out, q_track} !== 3'b001) begin
            bad++;
            $display("FAIL seq_release cycle %0d: s,r,q=%b required 001", i,
                     {s_out, r_out, q_track});
         end
      end
      clr_req = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         total++;
         if ({s_out, r_out, q_track} !== {1'b0, e == 6, e < 6}) begin
            bad++;
            $display("FAIL seq_clear edge %0d: s,r,q=%b required %b", e,
                     {s_out, r_out, q_track}, {1'b0, e == 6, e < 6});
         end
      end
      clr_req = 1'b0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_conflict();
      do_reset();
      set_req = 1'b1;
      clr_req = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         step();
         total++;
         if ({s_out, r_out, q_track, conflict, conflict_seen} !==
             {1'b0, 1'b0, 1'b0, e == 6, e >= 6}) begin
            bad++;
            $display("FAIL conflict edge %0d: s,r,q,c,cs=%b required %b", e,
                     {s_out, r_out, q_track, conflict, conflict_seen},
                     {1'b0, 1'b0, 1'b0, e == 6, e >= 6});
         end
      end
      set_req = 1'b0;
      clr_req = 1'b0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_reset_mid();
      set_req = 1'b1;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      step();
      total++;
      if ({s_out, r_out, q_track, conflict, conflict_seen} !== 5'b0) begin
         bad++;
         $display("FAIL reset_mid: outputs=%b required 00000",
                  {s_out, r_out, q_track, conflict, conflict_seen});
      end
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step();
         total++;
         if ({s_out, q_track} !== {e == 6, e >= 6}) begin
            bad++;
            $display("FAIL reset_mid_resume edge %0d: s,q=%b required %b", e,
                     {s_out, q_track}, {e == 6, e >= 6});
         end
      end
      set_req = 1'b0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic test_n1();
      int pulses;
      set1 = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         if (e == 2) set1 = 1'b0;
         step();
         total++;
         if ({s_out1, q_track1} !== {e == 3, e >= 3}) begin
            bad++;
            $display("FAIL n1_short edge %0d: s,q=%b required %b", e,
                     {s_out1, q_track1}, {e == 3, e >= 3});
         end
      end
      pulses = 0;
      set1 = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         if (e == 21) set1 = 1'b0;
         step();
         if (s_out1) pulses++;
         total++;
         if (s_out1 !== (e == 3)) begin
            bad++;
            $display("FAIL n1_hold edge %0d: s_out=%b required %b", e, s_out1, e == 3);
         end
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL n1_pulse_count: got %0d required 1", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_set_hold();
      test_bounce();
      test_sequence();
      test_conflict();
      test_reset_mid();
      test_n1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
